// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative radix-2 multiply/divide with architectural HI/LO registers.
// Revision 1.0
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             flush,
  input  logic             wehi,
  input  logic             welo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state, state_nx;
  logic [CW-1:0]      cnt;
  logic               is_div, neg_q, neg_r;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc, acc_step, prod_fix;
  logic               accept, last_step, fix_commit;

  // Operand conditioning: signed ops work on magnitudes, signs are restored in FIX.
  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  assign sgn   = ~op[0];
  assign a_neg = sgn & srca[WIDTH-1];
  assign b_neg = sgn & srcb[WIDTH-1];
  assign a_mag = a_neg ? -srca : srca;
  assign b_mag = b_neg ? -srcb : srcb;

  // One iteration: shift-add for multiply, restoring shift-subtract for divide.
  logic [WIDTH:0] mul_sum, div_tmp, div_diff;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
  assign div_tmp  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff = div_tmp - {1'b0, opnd};
  assign acc_step = !is_div   ? {mul_sum, acc[WIDTH-1:1]} :
                    div_diff[WIDTH] ? {div_tmp[WIDTH-1:0], acc[WIDTH-2:0], 1'b0} :
                                      {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  // Sign correction; a zero divisor leaves the dividend in the remainder slot.
  logic [WIDTH-1:0] quo, rem, hi_res, lo_res;
  assign quo      = acc[WIDTH-1:0];
  assign rem      = acc[2*WIDTH-1:WIDTH];
  assign prod_fix = neg_q ? -acc : acc;
  assign hi_res   = is_div ? (neg_r ? -rem : rem) : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res   = !is_div          ? prod_fix[WIDTH-1:0] :
                    (opnd == '0)     ? {WIDTH{1'b1}} :
                    neg_q            ? -quo : quo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = S_RUN;
      S_RUN:   if (flush) state_nx = S_IDLE;
               else if (last_step) state_nx = S_FIX;
      S_FIX:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state != S_IDLE);
    accept     = (state == S_IDLE) && start && !flush;
    last_step  = (state == S_RUN) && (cnt == CW'(WIDTH - 1));
    fix_commit = (state == S_FIX) && !flush;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc    <= '0;
    end else if (accept) begin
      cnt    <= '0;
      is_div <= op[1];
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      opnd   <= op[1] ? b_mag : a_mag;
      acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
    end else if (state == S_RUN) begin
      cnt    <= cnt + CW'(1);
      acc    <= acc_step;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= fix_commit;
      if (fix_commit) begin
        hi <= hi_res;
        lo <= lo_res;
      end else if (!busy) begin
        if (wehi) hi <= wdata;
        if (welo) lo <= wdata;
      end
    end
  end

endmodule

`default_nettype wire
